// File: rtl/audio_path_router_pkg.sv
// Shared types and saturation helpers for the audio sample router.
package audio_path_pkg;

   localparam int OUT_W_DEF = 16;
   localparam int SAT_W     = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COND,
      ST_SEND,
      ST_WAIT,
      ST_OUT
   } state_t;

   // Largest value representable in a w-bit two's complement word.
   function automatic logic signed [SAT_W-1:0] clamp_hi(input int w);
      logic signed [SAT_W-1:0] hi;
      hi = '0;
      for (int i = 0; i < SAT_W; i++) begin
         if (i < w - 1) hi[i] = 1'b1;
      end
      return hi;
   endfunction

   // Smallest value representable in a w-bit two's complement word.
   function automatic logic signed [SAT_W-1:0] clamp_lo(input int w);
      return ~clamp_hi(w);
   endfunction

   // Clamp a wide signed value into the w-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                   input int w);
      logic signed [SAT_W-1:0] r;
      if (v > clamp_hi(w))      r = clamp_hi(w);
      else if (v < clamp_lo(w)) r = clamp_lo(w);
      else                      r = v;
      return r;
   endfunction

endpackage

// File: rtl/audio_path_router_if.sv
// Sample-stream bus: ADC capture, effects send/return, DAC output handshake.
interface audio_path_router_if #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 16,
   parameter int CH_W  = 1
);
   logic             in_valid;
   logic [CH_W-1:0]  in_ch;
   logic [IN_W-1:0]  in_sample;
   logic             fx_send_valid;
   logic [OUT_W-1:0] fx_send_sample;
   logic             fx_ret_valid;
   logic [OUT_W-1:0] fx_ret_sample;
   logic             out_valid;
   logic             out_ready;
   logic [CH_W-1:0]  out_ch;
   logic [OUT_W-1:0] out_sample;

   modport master (
      output in_valid, in_ch, in_sample, fx_ret_valid, fx_ret_sample, out_ready,
      input  fx_send_valid, fx_send_sample, out_valid, out_ch, out_sample
   );

   modport slave (
      input  in_valid, in_ch, in_sample, fx_ret_valid, fx_ret_sample, out_ready,
      output fx_send_valid, fx_send_sample, out_valid, out_ch, out_sample
   );
endinterface

// File: rtl/audio_path_router_peak_meter.sv
// Peak-hold LED bar: captures the level of each delivered sample and
// lets the held level fall one LED per PEAK_DECAY idle cycles.
module peak_meter #(
   parameter int OUT_W      = 16,
   parameter int PEAK_DECAY = 2500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hs_valid,
   input  logic [OUT_W-1:0] hs_sample,
   output logic [9:0]       led_bar
);

   localparam int DCNT_W = $clog2(PEAK_DECAY + 1);

   logic [OUT_W-1:0]  mag;
   logic [3:0]        level;
   logic [3:0]        held_q;
   logic [DCNT_W-1:0] decay_cnt_q;

   // Magnitude of the delivered sample; the most negative code reads as full scale.
   always_comb begin
      if (!hs_sample[OUT_W-1])
         mag = hs_sample;
      else if (hs_sample == {1'b1, {(OUT_W-1){1'b0}}})
         mag = {1'b0, {(OUT_W-1){1'b1}}};
      else
         mag = OUT_W'(-hs_sample);
   end

   // Level = number of octave thresholds the magnitude reaches.
   always_comb begin
      level = '0;
      for (int i = 0; i < 10; i++) begin
         if (mag >= (OUT_W'(1) << (OUT_W - 11 + i))) level = level + 4'd1;
      end
   end

   // Hold the loudest level; decay on terminal count of the down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_q      <= '0;
         decay_cnt_q <= '0;
      end else if (hs_valid && (level >= held_q)) begin
         held_q      <= level;
         decay_cnt_q <= DCNT_W'(PEAK_DECAY - 1);
      end else if (decay_cnt_q == '0) begin
         decay_cnt_q <= DCNT_W'(PEAK_DECAY - 1);
         if (held_q != '0) held_q <= held_q - 4'd1;
      end else begin
         decay_cnt_q <= decay_cnt_q - DCNT_W'(1);
      end
   end

   // Thermometer code of the held level.
   always_comb begin
      led_bar = '0;
      for (int i = 0; i < 10; i++) led_bar[i] = (held_q > 4'(i));
   end

endmodule

// File: rtl/audio_path_router.sv
// ADC-to-DAC sample router: offset-binary conversion, per-channel DC
// removal, dry path with gain/saturation or effects send/return with
// timeout fallback, drop counting and a peak-hold meter.
//
// state | meaning
// IDLE  | waiting for an ADC sample
// COND  | convert / DC-correct, choose dry or effects route
// SEND  | one-cycle strobe of conditioned sample to effects
// WAIT  | waiting for effects return or timeout
// OUT   | sample presented to DAC stage until accepted
module audio_path_router
   import audio_path_pkg::*;
#(
   parameter int IN_W       = 12,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int N_CH       = 2,
   parameter int DC_SHIFT   = 10,
   parameter int FX_TIMEOUT = 1024,
   parameter int PEAK_DECAY = 2500000
) (
   input  logic        clk,
   input  logic        rst,
   audio_path_router_if.slave bus,
   input  logic        bypass,
   input  logic [2:0]  gain_shift,
   input  logic        dc_en,
   output logic        clip,
   output logic        fx_timeout,
   output logic [15:0] drop_cnt,
   output logic [9:0]  led_bar
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int ACC_W = OUT_W + DC_SHIFT;
   localparam int TMO_W = $clog2(FX_TIMEOUT + 1);

   state_t state_q, state_d;

   logic [CH_W-1:0]         cap_ch;
   logic [IN_W-1:0]         cap_sample;
   logic                    cap_bypass;
   logic [2:0]              cap_gain;
   logic signed [OUT_W-1:0] y_q;
   logic [OUT_W-1:0]        out_q;
   logic                    clip_q;
   logic                    fx_timeout_q;
   logic [15:0]             drop_q;
   logic [TMO_W-1:0]        tmo_cnt_q;
   logic signed [ACC_W-1:0] acc_q [N_CH];

   logic                    out_valid_c;
   logic                    fx_send_valid_c;

   logic signed [OUT_W-1:0] x_cond;
   logic signed [ACC_W-1:0] acc_cur;
   logic signed [ACC_W-1:0] dc_est;
   logic signed [ACC_W-1:0] diff_w;
   logic signed [OUT_W-1:0] y_cond;
   logic signed [SAT_W-1:0] gained;
   logic signed [SAT_W-1:0] gained_sat;

   // Offset-binary to signed: invert the MSB, then left-justify into OUT_W.
   assign x_cond  = {~cap_sample[IN_W-1], cap_sample[IN_W-2:0], {(OUT_W-IN_W){1'b0}}};
   assign acc_cur = acc_q[cap_ch];
   assign dc_est  = acc_cur >>> DC_SHIFT;
   assign diff_w  = ACC_W'(x_cond) - dc_est;

   // Conditioned sample and the gained/saturated dry-path value.
   always_comb begin
      y_cond     = dc_en ? OUT_W'(sat(SAT_W'(diff_w), OUT_W)) : x_cond;
      gained     = SAT_W'(y_cond) <<< cap_gain;
      gained_sat = sat(gained, OUT_W);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake strobes.
   always_comb begin
      state_d         = state_q;
      out_valid_c     = 1'b0;
      fx_send_valid_c = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.in_valid) state_d = ST_COND;
         ST_COND: state_d = cap_bypass ? ST_OUT : ST_SEND;
         ST_SEND: begin
            fx_send_valid_c = 1'b1;
            state_d         = ST_WAIT;
         end
         ST_WAIT: if (bus.fx_ret_valid || (tmo_cnt_q == '0)) state_d = ST_OUT;
         ST_OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture, conditioning, routing results, timeout and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_ch       <= '0;
         cap_sample   <= '0;
         cap_bypass   <= 1'b0;
         cap_gain     <= '0;
         y_q          <= '0;
         out_q        <= '0;
         clip_q       <= 1'b0;
         fx_timeout_q <= 1'b0;
         drop_q       <= '0;
         tmo_cnt_q    <= '0;
         for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
      end else begin
         clip_q       <= 1'b0;
         fx_timeout_q <= 1'b0;
         if (bus.in_valid && (state_q != ST_IDLE) && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  cap_ch     <= bus.in_ch;
                  cap_sample <= bus.in_sample;
                  cap_bypass <= bypass;
                  cap_gain   <= gain_shift;
               end
            end
            ST_COND: begin
               y_q <= y_cond;
               if (dc_en) acc_q[cap_ch] <= acc_cur + diff_w;
               if (cap_bypass) begin
                  out_q  <= OUT_W'(gained_sat);
                  clip_q <= (gained_sat != gained);
               end
            end
            ST_SEND: tmo_cnt_q <= TMO_W'(FX_TIMEOUT - 1);
            ST_WAIT: begin
               if (bus.fx_ret_valid) begin
                  out_q <= bus.fx_ret_sample;
               end else if (tmo_cnt_q == '0) begin
                  out_q        <= y_q;
                  fx_timeout_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_valid      = out_valid_c;
   assign bus.out_sample     = out_q;
   assign bus.out_ch         = cap_ch;
   assign bus.fx_send_valid  = fx_send_valid_c;
   assign bus.fx_send_sample = y_q;
   assign clip               = clip_q;
   assign fx_timeout         = fx_timeout_q;
   assign drop_cnt           = drop_q;

   peak_meter #(
      .OUT_W      (OUT_W),
      .PEAK_DECAY (PEAK_DECAY)
   ) u_peak (
      .clk       (clk),
      .rst       (rst),
      .hs_valid  (out_valid_c && bus.out_ready),
      .hs_sample (out_q),
      .led_bar   (led_bar)
   );

endmodule

// File: tb/tb_audio_path_router.sv
// Directed + randomized bench for audio_path_router against an arithmetic model.
module tb_audio_path_router;

   localparam int IN_W = 12;
   localparam int OUT_W = 16;
   localparam int N_CH = 2;
   localparam int CH_W = 1;
   localparam int DC_SHIFT = 4;
   localparam int FX_TIMEOUT = 1024;
   localparam int PEAK_DECAY = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bypass = 1'b0;
   logic [2:0]  gain_shift = '0;
   logic        dc_en = 1'b0;
   logic        clip;
   logic        fx_timeout;
   logic [15:0] drop_cnt;
   logic [9:0]  led_bar;

   int errors = 0;
   int checks = 0;

   longint acc_m [N_CH];

   audio_path_router_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CH_W(CH_W)) sig ();

   audio_path_router #(
      .IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH), .DC_SHIFT(DC_SHIFT),
      .FX_TIMEOUT(FX_TIMEOUT), .PEAK_DECAY(PEAK_DECAY)
   ) dut (
      .clk(clk), .rst(rst), .bus(sig), .bypass(bypass), .gain_shift(gain_shift),
      .dc_en(dc_en), .clip(clip), .fx_timeout(fx_timeout), .drop_cnt(drop_cnt),
      .led_bar(led_bar)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp16(input longint v, output bit clipped);
      longint r;
      r = v;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      clipped = (r != v);
      return int'(r);
   endfunction

   function automatic int to_signed(input int s);
      return (s - 2048) * 16;
   endfunction

   function automatic int model_dry(input int s, input int g, output bit clipped);
      longint v;
      v = longint'(to_signed(s)) * (longint'(1) << g);
      return clamp16(v, clipped);
   endfunction

   function automatic int level_of(input int v);
      int m;
      int l;
      m = (v < 0) ? -v : v;
      if (m > 32767) m = 32767;
      l = 0;
      for (int i = 0; i < 10; i++) if (m >= (1 << (5 + i))) l++;
      return l;
   endfunction

   function automatic int therm(input int l);
      return (1 << l) - 1;
   endfunction

   task automatic drive_in(input int ch, input int s, input bit byp, input int g);
      sig.in_valid  = 1'b1;
      sig.in_ch     = CH_W'(ch);
      sig.in_sample = IN_W'(s);
      bypass        = byp;
      gain_shift    = 3'(g);
      tick();
      sig.in_valid  = 1'b0;
   endtask

   task automatic handshake(input int stall, input logic [31:0] exp_s);
      for (int k = 0; k < stall; k++) begin
         tick();
         chk("hold_valid", 32'(sig.out_valid), 32'd1);
         chk("hold_sample", 32'(sig.out_sample), exp_s);
      end
      sig.out_ready = 1'b1;
      tick();
      sig.out_ready = 1'b0;
      chk("hs_release", 32'(sig.out_valid), 32'd0);
      chk("hs_clip_low", 32'(clip), 32'd0);
   endtask

   task automatic dry_txn(input int ch, input int s, input int g, input int stall,
                          output int exp_o);
      bit exp_c;
      exp_o = model_dry(s, g, exp_c);
      drive_in(ch, s, 1'b1, g);
      chk("dry_t1_valid", 32'(sig.out_valid), 32'd0);
      tick();
      chk("dry_valid", 32'(sig.out_valid), 32'd1);
      chk("dry_sample", 32'(sig.out_sample), 32'(exp_o & 32'hFFFF));
      chk("dry_ch", 32'(sig.out_ch), 32'(ch));
      chk("dry_clip", 32'(clip), 32'(exp_c));
      handshake(stall, 32'(exp_o & 32'hFFFF));
   endtask

   task automatic fx_txn(input int ch, input int s, input int d, input int ret, input int stall);
      int x;
      x = to_signed(s);
      drive_in(ch, s, 1'b0, 0);
      chk("fx_t1_send", 32'(sig.fx_send_valid), 32'd0);
      tick();
      chk("fx_send_valid", 32'(sig.fx_send_valid), 32'd1);
      chk("fx_send_sample", 32'(sig.fx_send_sample), 32'(x & 32'hFFFF));
      sig.fx_ret_valid  = 1'b1;
      sig.fx_ret_sample = 16'(ret ^ 32'hFFFF);
      tick();
      sig.fx_ret_valid  = 1'b0;
      chk("fx_send_pulse", 32'(sig.fx_send_valid), 32'd0);
      repeat (d - 1) tick();
      chk("fx_wait_valid", 32'(sig.out_valid), 32'd0);
      sig.fx_ret_valid  = 1'b1;
      sig.fx_ret_sample = 16'(ret);
      tick();
      sig.fx_ret_valid  = 1'b0;
      chk("fx_out_valid", 32'(sig.out_valid), 32'd1);
      chk("fx_out_sample", 32'(sig.out_sample), 32'(ret & 32'hFFFF));
      chk("fx_out_ch", 32'(sig.out_ch), 32'(ch));
      chk("fx_no_timeout", 32'(fx_timeout), 32'd0);
      handshake(stall, 32'(ret & 32'hFFFF));
   endtask

   initial begin
      int o;
      int held_s;
      int obs_s;
      sig.in_valid      = 1'b0;
      sig.in_ch         = '0;
      sig.in_sample     = '0;
      sig.fx_ret_valid  = 1'b0;
      sig.fx_ret_sample = '0;
      sig.out_ready     = 1'b0;
      acc_m[0] = 0;
      acc_m[1] = 0;

      // Reset state
      repeat (3) tick();
      chk("rst_out_valid", 32'(sig.out_valid), 32'd0);
      chk("rst_out_sample", 32'(sig.out_sample), 32'd0);
      chk("rst_out_ch", 32'(sig.out_ch), 32'd0);
      chk("rst_fx_send_valid", 32'(sig.fx_send_valid), 32'd0);
      chk("rst_fx_send_sample", 32'(sig.fx_send_sample), 32'd0);
      chk("rst_clip", 32'(clip), 32'd0);
      chk("rst_fx_timeout", 32'(fx_timeout), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_led_bar", 32'(led_bar), 32'd0);
      rst = 1'b0;
      tick();

      // Dry path directed values
      dry_txn(0, 12'h800, 0, 0, o);
      dry_txn(1, 12'hFFF, 0, 1, o);
      chk("dry_fff_const", 32'(o & 32'hFFFF), 32'h7FF0);
      dry_txn(0, 12'h000, 0, 0, o);
      chk("dry_000_const", 32'(o & 32'hFFFF), 32'h8000);
      dry_txn(1, 12'hFFF, 2, 2, o);
      chk("dry_gain_const", 32'(o & 32'hFFFF), 32'h7FFF);

      // Effects path, return 5 cycles after send
      fx_txn(1, 12'hC00, 5, 16'h1234, 0);

      // Effects timeout
      drive_in(0, 12'hC00, 1'b0, 0);
      tick();
      chk("tmo_send_sample", 32'(sig.fx_send_sample), 32'h4000);
      repeat (FX_TIMEOUT) tick();
      chk("tmo_early_valid", 32'(sig.out_valid), 32'd0);
      chk("tmo_early_flag", 32'(fx_timeout), 32'd0);
      tick();
      chk("tmo_valid", 32'(sig.out_valid), 32'd1);
      chk("tmo_flag", 32'(fx_timeout), 32'd1);
      chk("tmo_sample", 32'(sig.out_sample), 32'h4000);
      tick();
      chk("tmo_flag_pulse", 32'(fx_timeout), 32'd0);
      handshake(0, 32'h4000);

      // Reset in the middle of an effects transaction
      drive_in(1, 12'h900, 1'b0, 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_send", 32'(sig.fx_send_valid), 32'd0);
      chk("midrst_sample", 32'(sig.out_sample), 32'd0);
      repeat (4) tick();
      chk("midrst_no_out", 32'(sig.out_valid), 32'd0);

      // Stall with drops
      drive_in(1, 12'h900, 1'b1, 0);
      tick();
      held_s = to_signed(12'h900);
      for (int k = 0; k < 20; k++) begin
         if (k == 3 || k == 8 || k == 13) begin
            sig.in_valid  = 1'b1;
            sig.in_sample = IN_W'($urandom_range(0, 4095));
         end
         tick();
         sig.in_valid = 1'b0;
         chk("stall_sample", 32'(sig.out_sample), 32'(held_s & 32'hFFFF));
      end
      chk("stall_valid", 32'(sig.out_valid), 32'd1);
      chk("stall_drop_cnt", 32'(drop_cnt), 32'd3);
      sig.out_ready = 1'b1;
      sig.in_valid  = 1'b1;
      tick();
      sig.out_ready = 1'b0;
      sig.in_valid  = 1'b0;
      chk("hs_drop_cnt", 32'(drop_cnt), 32'd4);
      repeat (3) tick();
      chk("hs_drop_no_out", 32'(sig.out_valid), 32'd0);

      // Randomized traffic on both routes
      for (int n = 0; n < 40; n++) begin
         int ch, s, g, st;
         ch = $urandom_range(0, 1);
         s  = $urandom_range(0, 4095);
         g  = $urandom_range(0, 7);
         st = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) dry_txn(ch, s, g, st, o);
         else fx_txn(ch, s, $urandom_range(1, 20), $urandom_range(0, 65535), st);
      end
      chk("rand_drop_cnt", 32'(drop_cnt), 32'd4);

      // DC removal on channel 1, then a first sample on untouched channel 0
      dc_en = 1'b1;
      obs_s = 0;
      for (int n = 0; n < 201; n++) begin
         int ch, x, y;
         longint est, d;
         bit c;
         ch = (n == 200) ? 0 : 1;
         x = to_signed(12'hC00);
         est = acc_m[ch] >>> DC_SHIFT;
         d = longint'(x) - est;
         y = clamp16(d, c);
         acc_m[ch] = acc_m[ch] + d;
         drive_in(ch, 12'hC00, 1'b1, 0);
         tick();
         chk("dc_valid", 32'(sig.out_valid), 32'd1);
         chk("dc_sample", 32'(sig.out_sample), 32'(y & 32'hFFFF));
         if (n == 199) obs_s = int'($signed(sig.out_sample));
         handshake(0, 32'(y & 32'hFFFF));
      end
      chk("dc_settled", 32'((obs_s < 256 && obs_s > -256) ? 1 : 0), 32'd1);
      dc_en = 1'b0;

      // Peak meter: full scale then decay to zero
      dry_txn(0, 12'hFFF, 0, 0, o);
      chk("peak_full", 32'(led_bar), 32'h3FF);
      repeat (PEAK_DECAY - 1) tick();
      chk("peak_hold_edge", 32'(led_bar), 32'h3FF);
      tick();
      chk("peak_decay1", 32'(led_bar), 32'h1FF);
      for (int k = 2; k <= 10; k++) begin
         repeat (PEAK_DECAY) tick();
         chk("peak_decay", 32'(led_bar), 32'(therm(10 - k)));
      end
      repeat (PEAK_DECAY) tick();
      chk("peak_floor", 32'(led_bar), 32'd0);

      // Peak level thresholds with rising magnitudes
      begin
         int svals [5];
         svals = '{2049, 2050, 2040, 2148, 0};
         for (int k = 0; k < 5; k++) begin
            dry_txn(1, svals[k], 0, 0, o);
            chk("peak_level", 32'(led_bar), 32'(therm(level_of(o))));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_path_router.md
# audio_path_router

Parametrised multi-channel sample path between the on-chip ADC and the I2S DAC output stage. It replaces the fixed single-channel ADC → effects → DAC register glue. It converts offset-binary ADC samples to signed, full-scale DAC words. Other duties: optional DC-offset removal, routing each sample either through the effects pipeline (send/return handshake with timeout fallback) or through a gained bypass with saturation, and driving a peak-hold LED bar meter.

## Interface
- IN_W, 12 — ADC sample width (unsigned offset-binary)
- OUT_W, 16 — DAC sample width (signed two's complement); OUT_W > IN_W
- N_CH, 2 — channel count; CH_W = max(1, $clog2(N_CH))
- DC_SHIFT, 10 — DC tracker time constant (2^DC_SHIFT samples)
- FX_TIMEOUT, 1024 — max cycles to wait for effects return
- PEAK_DECAY, 2500000 — cycles per one-LED decay step of the peak meter

Ports:
- clk  in  1  — system clock, single clock domain
- rst  in  1  — synchronous, active-high reset
- in_valid  in  1  — one-cycle strobe, new ADC sample
- in_ch  in  CH_W  — channel of in_sample
- in_sample  in  IN_W  — ADC sample
- bypass  in  1  — 1: dry path, 0: effects path (sampled at capture)
- gain_shift  in  3  — left shift applied on dry path
- dc_en  in  1  — enable DC removal
- fx_send_valid  out  1  — one-cycle strobe to effects
- fx_send_sample  out  OUT_W  — conditioned sample to effects
- fx_ret_valid  in  1  — effects result strobe
- fx_ret_sample  in  OUT_W  — effects result
- out_valid  out  1  — sample ready for DAC stage
- out_ready  in  1  — DAC stage accepts
- out_ch  out  CH_W  — channel of out_sample
- out_sample  out  OUT_W  — DAC sample, stable while out_valid
- clip  out  1  — one-cycle pulse when dry path saturates
- fx_timeout  out  1  — one-cycle pulse on effects timeout
- drop_cnt  out  16  — samples dropped while busy, saturating
- led_bar  out  10  — peak meter thermometer

## Operation
- Conversion: x = (in_sample − 2^(IN_W−1)) sign-extended to OUT_W, then << (OUT_W−IN_W).
- DC removal, per channel (N_CH registers of OUT_W+DC_SHIFT bits): acc += x − (acc >>> DC_SHIFT); y = dc_en ? sat(x − (acc >>> DC_SHIFT)) : x. Accumulators update only while dc_en=1 and hold otherwise.
- FSM states: IDLE, COND, SEND, WAIT, OUT.
  - IDLE: in_valid captures in_ch, in_sample, bypass, gain_shift → COND.
  - COND: computes y. If bypass, out_sample = sat(y << gain_shift), clip pulses if clamped → OUT. Otherwise → SEND.
  - SEND: fx_send_valid=1 for one cycle with y → WAIT. The timeout counter is cleared.
  - WAIT: fx_ret_valid → out_sample = fx_ret_sample → OUT. If the counter reaches FX_TIMEOUT first, out_sample = y (unity gain), fx_timeout pulses → OUT.
  - OUT: out_valid=1. When out_ready=1 in the same cycle → IDLE.
- in_valid in any state other than IDLE: the sample is dropped and drop_cnt increments (saturates at 0xFFFF).
- fx_ret_valid outside WAIT is ignored.
- Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Peak meter on each out handshake:
  - m = |out_sample|, with −2^(OUT_W−1) mapped to max.
  - Level L = number of i in 0..9 with m ≥ 2^(OUT_W−11+i).
  - If L ≥ held level, held = L and the decay counter restarts.
  - Every PEAK_DECAY cycles without an update, held level decrements by 1 (floor 0).
  - led_bar = thermometer of held level (bit 0 lowest).

## Timing
- Reset: all outputs 0, FSM IDLE, DC accumulators 0, peak level 0, timeout/decay counters 0. Reset mid-transaction aborts it with no output.
- Dry path: in_valid at cycle t → out_valid at t+2.
- Effects path: fx_send_valid at t+2. fx_ret_valid at cycle r → out_valid at r+1.
- Timeout: with no return, fx_timeout pulses and out_valid rises at t+3+FX_TIMEOUT.
- out_valid/out_sample/out_ch are held unchanged until the out_ready cycle. A new in_valid is accepted no earlier than the cycle after the handshake.
- in_valid on the handshake cycle is dropped.
- led_bar updates the cycle after the handshake.

## Structure
- Package audio_path_pkg: FSM state enum, sat() function, clamp constants derived from OUT_W.
- One sub-module: peak_meter (handshake sample in, led_bar out, decay counter).
- DC tracker and FSM stay inline.

## Test plan
All tests use default parameters with dc_en=0 unless stated.
- Reset → all outputs 0. Then bypass=1, gain_shift=0, in_sample=0x800 → out_sample 0x0000 at t+2.
- Bypass, gain_shift=0: 0xFFF → 0x7FF0, 0x000 → 0x8000. gain_shift=2, 0xFFF → 0x7FFF with clip pulse.
- bypass=0, 0xC00 → fx_send_sample 0x4000 at t+2. fx_ret_sample 0x1234 returned 5 cycles later → out_valid at t+8 with 0x1234.
- bypass=0 with no return → fx_timeout pulse and out_sample 0x4000 at t+3+FX_TIMEOUT.
- Hold out_ready=0 for 20 cycles while pulsing in_valid 3 times → out_sample unchanged, drop_cnt=3.
- dc_en=1, DC_SHIFT=4, constant 0xC00 for 200 samples → |out_sample| below 0x0100 by the end. Full-scale output → led_bar=0x3FF, then decays one LED per PEAK_DECAY (shortened to 100) cycles to 0.
